sd_rx_blk_ctrl: RTL and testbench

Receive-side block sequencer for the SD data path, clocked on the SD-card clock domain. It arms on a host command and detects each data block's start bit on DAT[3:0]. It streams the payload nibbles into the packing RX FIFO write port, then checks the per-line CRC16 and the end bit, and repeats for the programmed block count. It reports completion and CRC, end-bit, overflow and timeout errors to the register/DMA side.

---
 rtl/sd_rx_blk_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_sd_rx_blk_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_rx_blk_ctrl.sv
// sd_rx_blk_ctrl: SD receive-side block sequencer.
// Waits for each block's start bit, streams the payload nibbles into the RX FIFO,
// checks the per-line CRC16 and the end bit, and repeats for the programmed block count.
module sd_rx_blk_ctrl #(
  parameter int unsigned BLKSIZE_W = 12,
  parameter int unsigned BLKCNT_W  = 16,
  parameter int unsigned TOUT_W    = 24
) (
  input  logic                 wclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BLKSIZE_W-1:0] blksize,
  input  logic [BLKCNT_W-1:0]  blkcnt,
  input  logic [TOUT_W-1:0]    tout,
  input  logic [3:0]           dat_i,
  input  logic                 fifo_full,
  output logic [3:0]           fifo_d,
  output logic                 fifo_wr,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_err,
  output logic                 end_err,
  output logic                 ovf_err,
  output logic                 tout_err,
  output logic [BLKCNT_W-1:0]  blk_done
);

  localparam int unsigned NCNT_W = BLKSIZE_W + 1;
  localparam int unsigned CCNT_W = 4;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned LINES  = 4;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_S = 3'd1,
    S_DATA   = 3'd2,
    S_CRC    = 3'd3,
    S_ENDB   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t                          state_q, state_nxt;
  logic [BLKSIZE_W-1:0]            cfg_blksize_q, cfg_blksize_nxt;
  logic [BLKCNT_W-1:0]             cfg_blkcnt_q, cfg_blkcnt_nxt;
  logic [TOUT_W-1:0]               cfg_tout_q, cfg_tout_nxt;
  logic [TOUT_W-1:0]               tcnt_q, tcnt_nxt;
  logic [NCNT_W-1:0]               ncnt_q, ncnt_nxt;
  logic [CCNT_W-1:0]               ccnt_q, ccnt_nxt;
  logic [LINES-1:0][CRC_W-1:0]     crc_q, crc_nxt;
  logic                            mism_q, mism_nxt;

  logic [3:0]                      fifo_d_nxt;
  logic                            fifo_wr_nxt;
  logic                            busy_nxt;
  logic                            done_nxt;
  logic                            crc_err_nxt;
  logic                            end_err_nxt;
  logic                            ovf_err_nxt;
  logic                            tout_err_nxt;
  logic [BLKCNT_W-1:0]             blk_done_nxt;

  logic [TOUT_W:0]                 tcnt_inc_c;
  logic [BLKCNT_W:0]               blk_inc_c;

  // One serial CCITT CRC16 step (x^16+x^12+x^5+1) for a single data bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb       = c[CRC_W-1] ^ b;
    crc_step = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
  endfunction

  assign tcnt_inc_c = {1'b0, tcnt_q} + (TOUT_W+1)'(1);
  assign blk_inc_c  = {1'b0, blk_done} + (BLKCNT_W+1)'(1);

  // State and datapath register; every register loads its next value from the comb block.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cfg_blksize_q <= '0;
      cfg_blkcnt_q  <= '0;
      cfg_tout_q    <= '0;
      tcnt_q        <= '0;
      ncnt_q        <= '0;
      ccnt_q        <= '0;
      crc_q         <= '0;
      mism_q        <= 1'b0;
      fifo_d        <= 4'h0;
      fifo_wr       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      crc_err       <= 1'b0;
      end_err       <= 1'b0;
      ovf_err       <= 1'b0;
      tout_err      <= 1'b0;
      blk_done      <= '0;
    end else begin
      state_q       <= state_nxt;
      cfg_blksize_q <= cfg_blksize_nxt;
      cfg_blkcnt_q  <= cfg_blkcnt_nxt;
      cfg_tout_q    <= cfg_tout_nxt;
      tcnt_q        <= tcnt_nxt;
      ncnt_q        <= ncnt_nxt;
      ccnt_q        <= ccnt_nxt;
      crc_q         <= crc_nxt;
      mism_q        <= mism_nxt;
      fifo_d        <= fifo_d_nxt;
      fifo_wr       <= fifo_wr_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      crc_err       <= crc_err_nxt;
      end_err       <= end_err_nxt;
      ovf_err       <= ovf_err_nxt;
      tout_err      <= tout_err_nxt;
      blk_done      <= blk_done_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides everything and leaves flags untouched.
  always_comb begin
    state_nxt       = state_q;
    cfg_blksize_nxt = cfg_blksize_q;
    cfg_blkcnt_nxt  = cfg_blkcnt_q;
    cfg_tout_nxt    = cfg_tout_q;
    tcnt_nxt        = tcnt_q;
    ncnt_nxt        = ncnt_q;
    ccnt_nxt        = ccnt_q;
    crc_nxt         = crc_q;
    mism_nxt        = mism_q;
    fifo_d_nxt      = fifo_d;
    fifo_wr_nxt     = 1'b0;
    crc_err_nxt     = crc_err;
    end_err_nxt     = end_err;
    ovf_err_nxt     = ovf_err;
    tout_err_nxt    = tout_err;
    blk_done_nxt    = blk_done;

    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_blksize_nxt = blksize;
            cfg_blkcnt_nxt  = (blkcnt == '0) ? BLKCNT_W'(1) : blkcnt;
            cfg_tout_nxt    = tout;
            crc_err_nxt     = 1'b0;
            end_err_nxt     = 1'b0;
            ovf_err_nxt     = 1'b0;
            tout_err_nxt    = 1'b0;
            blk_done_nxt    = '0;
            tcnt_nxt        = '0;
            state_nxt       = S_WAIT_S;
          end
        end

        S_WAIT_S: begin
          if (dat_i == 4'h0) begin
            crc_nxt   = '0;
            mism_nxt  = 1'b0;
            ncnt_nxt  = NCNT_W'({cfg_blksize_q, 1'b0}) - NCNT_W'(1);
            state_nxt = S_DATA;
          end else if (tcnt_inc_c >= {1'b0, cfg_tout_q}) begin
            tout_err_nxt = 1'b1;
            state_nxt    = S_FIN;
          end else begin
            tcnt_nxt = tcnt_inc_c[TOUT_W-1:0];
          end
        end

        S_DATA: begin
          if (fifo_full) begin
            ovf_err_nxt = 1'b1;
            state_nxt   = S_FIN;
          end else begin
            fifo_d_nxt  = dat_i;
            fifo_wr_nxt = 1'b1;
            for (int i = 0; i < int'(LINES); i++) begin
              crc_nxt[i] = crc_step(crc_q[i], dat_i[i]);
            end
            if (ncnt_q == '0) begin
              ccnt_nxt  = CCNT_W'(CRC_W - 1);
              state_nxt = S_CRC;
            end else begin
              ncnt_nxt = ncnt_q - NCNT_W'(1);
            end
          end
        end

        S_CRC: begin
          for (int i = 0; i < int'(LINES); i++) begin
            if (dat_i[i] != crc_q[i][ccnt_q]) begin
              mism_nxt = 1'b1;
            end
          end
          if (ccnt_q == '0) begin
            state_nxt = S_ENDB;
          end else begin
            ccnt_nxt = ccnt_q - CCNT_W'(1);
          end
        end

        S_ENDB: begin
          if (dat_i != 4'hF) begin
            end_err_nxt = 1'b1;
          end
          if (mism_q) begin
            crc_err_nxt = 1'b1;
            state_nxt   = S_FIN;
          end else if (dat_i != 4'hF) begin
            state_nxt = S_FIN;
          end else begin
            blk_done_nxt = blk_inc_c[BLKCNT_W-1:0];
            if (blk_inc_c < {1'b0, cfg_blkcnt_q}) begin
              tcnt_nxt  = '0;
              state_nxt = S_WAIT_S;
            end else begin
              state_nxt = S_FIN;
            end
          end
        end

        S_FIN: begin
          state_nxt = S_IDLE;
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_FIN);
  end

endmodule

// File: tb/tb_sd_rx_blk_ctrl.sv
// tb_sd_rx_blk_ctrl: randomized self-checking bench for sd_rx_blk_ctrl.
// A transaction-level model predicts the FIFO write stream, done timing and final flags.
module tb_sd_rx_blk_ctrl;

  localparam int unsigned BLKSIZE_W = 12;
  localparam int unsigned BLKCNT_W  = 16;
  localparam int unsigned TOUT_W    = 24;

  logic                 wclk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [BLKSIZE_W-1:0] blksize;
  logic [BLKCNT_W-1:0]  blkcnt;
  logic [TOUT_W-1:0]    tout;
  logic [3:0]           dat_i;
  logic                 fifo_full;
  logic [3:0]           fifo_d;
  logic                 fifo_wr;
  logic                 busy;
  logic                 done;
  logic                 crc_err;
  logic                 end_err;
  logic                 ovf_err;
  logic                 tout_err;
  logic [BLKCNT_W-1:0]  blk_done;

  sd_rx_blk_ctrl #(
    .BLKSIZE_W(BLKSIZE_W),
    .BLKCNT_W (BLKCNT_W),
    .TOUT_W   (TOUT_W)
  ) dut (
    .wclk     (wclk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .blksize  (blksize),
    .blkcnt   (blkcnt),
    .tout     (tout),
    .dat_i    (dat_i),
    .fifo_full(fifo_full),
    .fifo_d   (fifo_d),
    .fifo_wr  (fifo_wr),
    .busy     (busy),
    .done     (done),
    .crc_err  (crc_err),
    .end_err  (end_err),
    .ovf_err  (ovf_err),
    .tout_err (tout_err),
    .blk_done (blk_done)
  );

  always #5 wclk = ~wclk;

  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_busy = 1'b0;

  // Observed FIFO writes and done pulses, stamped with the posedge count.
  logic [3:0] mon_d[$];
  int         mon_c[$];
  int         mon_done[$];

  always @(negedge wclk) begin
    if (fifo_wr) begin
      mon_d.push_back(fifo_d);
      mon_c.push_back(cyc);
    end
    if (done) mon_done.push_back(cyc);
  end

  // Model expectations for the current transfer.
  logic [3:0] exp_d[$];
  int         exp_c[$];
  int         exp_done;
  bit         e_crc, e_end, e_ovf, e_tout;
  int         e_blk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // CRC16 as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1 (long division).
  function automatic logic [15:0] line_crc(input logic [3:0] nib[$], input int line);
    bit          r[];
    bit [16:0]   g;
    int          n;
    logic [15:0] res;
    g = 17'h11021;
    n = nib.size();
    r = new[n + 16];
    for (int k = 0; k < n; k++) r[k] = nib[k][line];
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        for (int j = 0; j <= 16; j++) r[i+j] = r[i+j] ^ g[16-j];
      end
    end
    for (int j = 0; j < 16; j++) res[15-j] = r[n+j];
    return res;
  endfunction

  // Drive one bus cycle at the falling edge; sc = posedge index that samples it.
  task automatic tick(input logic [3:0] d, input logic full, input logic ab, output int sc);
    @(negedge wclk);
    if (chk_busy) begin
      check("busy_rise", busy, 1);
      chk_busy = 1'b0;
    end
    start     = 1'b0;
    dat_i     = d;
    fifo_full = full;
    abort     = ab;
    sc        = cyc + 1;
  endtask

  // One complete transfer. stop_kind 1 = abort at data nibble stop_at, 2 = rst at CRC nibble stop_at.
  task automatic run_xfer(input int bsz, input int cnt, input int tv, input int gap, input bit ramp,
                          input int flip_blk, input int end_blk, input int full_blk, input int full_at,
                          input int stop_blk, input int stop_kind, input int stop_at, input bit poke);
    int          eff, s, sc, w0, nmin;
    bit          halt, full, ab;
    logic [3:0]  nib[$];
    logic [15:0] crcs[4];
    logic [3:0]  v;

    mon_d.delete(); mon_c.delete(); mon_done.delete();
    exp_d.delete(); exp_c.delete();
    exp_done = -1;
    e_crc = 0; e_end = 0; e_ovf = 0; e_tout = 0; e_blk = 0;

    @(negedge wclk);
    start     = 1'b1;
    blksize   = BLKSIZE_W'(bsz);
    blkcnt    = BLKCNT_W'(cnt);
    tout      = TOUT_W'(tv);
    dat_i     = 4'hF;
    fifo_full = 1'b0;
    abort     = 1'b0;
    chk_busy  = 1'b1;

    eff  = (cnt == 0) ? 1 : cnt;
    halt = 1'b0;
    for (int b = 0; b < eff && !halt; b++) begin
      nib.delete();
      for (int k = 0; k < 2*bsz; k++) nib.push_back(ramp ? 4'(k + 1) : 4'($urandom_range(0, 15)));
      for (int i = 0; i < 4; i++) crcs[i] = line_crc(nib, i);

      w0 = -1;
      for (int g = 0; g < gap; g++) begin
        tick(4'hF, 1'b0, 1'b0, sc);
        if (g == 0) w0 = sc;
      end
      if (gap >= tv) begin
        e_tout   = 1'b1;
        exp_done = w0 + tv - 1;
        halt     = 1'b1;
        break;
      end

      tick(4'h0, 1'b0, 1'b0, s);
      for (int k = 0; k < 2*bsz; k++) begin
        full = (b == full_blk) && (k == full_at);
        ab   = (b == stop_blk) && (stop_kind == 1) && (k == stop_at);
        tick(nib[k], full, ab, sc);
        if (poke && b == 0 && k == 1) begin
          start   = 1'b1;
          blksize = BLKSIZE_W'(8);
        end
        if (ab) begin
          halt = 1'b1;
          break;
        end
        if (full) begin
          e_ovf    = 1'b1;
          exp_done = sc;
          halt     = 1'b1;
          break;
        end
        exp_d.push_back(nib[k]);
        exp_c.push_back(sc);
      end
      if (halt) break;

      for (int j = 0; j < 16; j++) begin
        v = {crcs[3][15-j], crcs[2][15-j], crcs[1][15-j], crcs[0][15-j]};
        if (b == flip_blk && j == 3) v[2] = ~v[2];
        tick(v, 1'b0, 1'b0, sc);
        if (b == stop_blk && stop_kind == 2 && j == stop_at) begin
          #1 rst = 1'b1;
          #1;
          check("rst_fifo_wr", fifo_wr, 0);
          check("rst_busy", busy, 0);
          check("rst_blk_done", blk_done, 0);
          check("rst_done", done, 0);
          e_blk = 0;
          halt  = 1'b1;
          @(negedge wclk);
          rst = 1'b0;
          break;
        end
      end
      if (halt) break;

      tick((b == end_blk) ? 4'hE : 4'hF, 1'b0, 1'b0, sc);
      if (b == end_blk) e_end = 1'b1;
      if (b == flip_blk) e_crc = 1'b1;
      if (e_end || e_crc) begin
        exp_done = sc;
        halt     = 1'b1;
      end else begin
        e_blk++;
        if (b == eff - 1) exp_done = sc;
      end
    end

    // Trailing traffic that must be ignored once the transfer has ended.
    tick(4'h0, 1'b0, 1'b0, sc);
    for (int k = 0; k < 12; k++) tick(4'($urandom_range(0, 15)), 1'b0, 1'b0, sc);
    for (int k = 0; k < 4; k++) tick(4'hF, 1'b0, 1'b0, sc);

    check("wr_count", mon_d.size(), exp_d.size());
    nmin = (mon_d.size() < exp_d.size()) ? mon_d.size() : exp_d.size();
    for (int i = 0; i < nmin; i++) begin
      check("wr_data", mon_d[i], exp_d[i]);
      check("wr_cycle", mon_c[i], exp_c[i]);
    end
    check("done_count", mon_done.size(), (exp_done >= 0) ? 1 : 0);
    if (mon_done.size() > 0 && exp_done >= 0) check("done_cycle", mon_done[0], exp_done);
    check("crc_err", crc_err, e_crc);
    check("end_err", end_err, e_end);
    check("ovf_err", ovf_err, e_ovf);
    check("tout_err", tout_err, e_tout);
    check("blk_done", blk_done, e_blk);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bsz, cnt, gap;
    rst = 1'b1; start = 1'b0; abort = 1'b0; blksize = '0; blkcnt = '0; tout = '0;
    dat_i = 4'hF; fifo_full = 1'b0;
    repeat (3) @(negedge wclk);
    rst = 1'b0;
    @(negedge wclk);
    check("reset_fifo_d", fifo_d, 0);
    check("reset_fifo_wr", fifo_wr, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_errs", {crc_err, end_err, ovf_err, tout_err}, 0);
    check("reset_blk_done", blk_done, 0);

    // Single ramp block, with a start pulse while busy that must be ignored.
    run_xfer(4, 1, 50, 3, 1'b1, -1, -1, -1, -1, -1, 0, -1, 1'b1);
    // Three 512-byte blocks, 5 idle cycles between; tout restarts per block.
    run_xfer(512, 3, 10, 5, 1'b0, -1, -1, -1, -1, -1, 0, -1, 1'b0);
    // CRC bit flipped on DAT2 in block 2 of 3.
    run_xfer(16, 3, 20, 2, 1'b0, 1, -1, -1, -1, -1, 0, -1, 1'b0);
    // Bad end bit in block 1 of 2.
    run_xfer(8, 2, 20, 1, 1'b0, -1, 0, -1, -1, -1, 0, -1, 1'b0);
    // FIFO full at the 5th data nibble.
    run_xfer(4, 1, 20, 2, 1'b0, -1, -1, 0, 4, -1, 0, -1, 1'b0);
    // No start bit within 100 cycles.
    run_xfer(4, 1, 100, 110, 1'b0, -1, -1, -1, -1, -1, 0, -1, 1'b0);

    // start and abort together in IDLE: abort wins and flags are not cleared.
    @(negedge wclk);
    start = 1'b1; abort = 1'b1; blksize = BLKSIZE_W'(4); blkcnt = BLKCNT_W'(1);
    @(negedge wclk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_tout_hold", tout_err, 1);
    repeat (3) @(negedge wclk);
    check("start_abort_still_idle", busy, 0);

    // abort mid-DATA of block 2: blk_done holds 1, no done.
    run_xfer(8, 2, 20, 3, 1'b0, -1, -1, -1, -1, 1, 1, 5, 1'b0);
    // rst during CRC of block 2.
    run_xfer(4, 2, 20, 2, 1'b0, -1, -1, -1, -1, 1, 2, 7, 1'b0);
    // blkcnt of 0 behaves as 1.
    run_xfer(4, 0, 20, 2, 1'b0, -1, -1, -1, -1, -1, 0, -1, 1'b0);

    // Random sizes, counts and gaps.
    for (int t = 0; t < 6; t++) begin
      bsz = 4 * $urandom_range(1, 8);
      cnt = $urandom_range(1, 3);
      gap = $urandom_range(0, 10);
      run_xfer(bsz, cnt, 30, gap, 1'b0, -1, -1, -1, -1, -1, 0, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
